// File: rtl/axis_slave_rx.sv
// AXI4-Stream sink: show-ahead FIFO with backpressure,
// packet length checker and packet/error counters.
module axis_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACKET_SIZE = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_en,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  len_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(PACKET_SIZE);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BC_LAST = BW'(PACKET_SIZE - 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic {IDLE, BODY} state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            rdy_en;
  logic            full;
  logic            push;
  logic            pop;
  logic            err;
  state_t          state;
  state_t          state_n;
  logic [BW-1:0]   bc;
  logic [BW-1:0]   bc_n;

  assign full     = (count == DEPTH);
  assign s_tready = rdy_en & ~full;
  assign rd_valid = |count;
  assign push     = s_tvalid & s_tready;
  assign pop      = rd_en & rd_valid;
  assign head     = mem[rd_ptr];
  assign rd_data  = rd_valid ? head.data : '0;
  assign rd_last  = rd_valid & head.last;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: s_tlast, data: s_tdata};
  end

  // full blocks push even when popping: no bypass path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_en <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bc    <= '0;
    end else begin
      state <= state_n;
      bc    <= bc_n;
    end
  end

  always_comb begin
    state_n = state;
    bc_n    = bc;
    err     = 1'b0;
    if (push) begin
      unique case (state)
        IDLE: begin
          if (s_tlast) begin
            err = 1'b1;
          end else begin
            state_n = BODY;
            bc_n    = BW'(1);
          end
        end
        BODY: begin
          if (s_tlast) begin
            err     = (bc != BC_LAST);
            state_n = IDLE;
            bc_n    = '0;
          end else if (bc == BC_LAST) begin
            err     = 1'b1;
            state_n = IDLE;
            bc_n    = '0;
          end else begin
            bc_n = bc + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          bc_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
      err_count <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= err;
      if (push && s_tlast) pkt_count <= pkt_count + 1'b1;
      if (err && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_slave_rx.sv
// Self-checking bench for axis_slave_rx: scoreboard on the
// read port plus table-driven packet lengths and corner sequences.
module tb_axis_slave_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [7:0]  rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        rd_en = 1'b0;
  logic [15:0] pkt_count;
  logic [15:0] err_count;
  logic        len_err;

  axis_slave_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_valid  (rd_valid),
    .rd_en     (rd_en),
    .pkt_count (pkt_count),
    .err_count (err_count),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int errs;
  } vec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_pkts = 0;
  int         exp_errs = 0;
  int         pulses = 0;
  int         rd_mode = 0;
  logic [8:0] exp_q[$];
  vec_t       vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_pkt_count"}, pkt_count, exp_pkts);
    chk({nm, "_err_count"}, err_count, exp_errs);
    chk({nm, "_len_err_pulses"}, pulses, exp_errs);
  endtask

  always @(posedge clk) begin
    #1;
    case (rd_mode)
      0: rd_en = 1'b0;
      1: rd_en = 1'b1;
      2: rd_en = 1'($urandom_range(0, 1));
      default: begin
        rd_en   = 1'b1;
        rd_mode = 0;
      end
    endcase
  end

  always @(negedge clk) begin
    if (reset_n && len_err) pulses++;
    if (reset_n && rd_valid && rd_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_extra: got data %0h expected no beat", rd_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e[7:0]);
        chk("rd_last", rd_last, e[8]);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!s_tready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: tready got 0 expected 1");
      s_tvalid = 1'b0;
      return;
    end
    exp_q.push_back({l, d});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    rd_mode = 1;
    while ((exp_q.size() != 0 || rd_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: queue %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8, 0};
    vecs[1] = '{5, 1};
    vecs[2] = '{10, 2};
    vecs[3] = '{1, 1};
    vecs[4] = '{2, 1};
    vecs[5] = '{9, 2};
    vecs[6] = '{16, 1};
    vecs[7] = '{7, 1};

    // reset with source already valid
    reset_n  = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'hA5;
    s_tlast  = 1'b0;
    #22;
    chk("rst_tready", s_tready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err_count", err_count, 0);
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("tready_pre_en", s_tready, 0);
    @(negedge clk);
    chk("tready_post_en", s_tready, 1);
    @(posedge clk);
    #1;

    // nominal 8-beat packet
    rd_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(8'(i), i == 7);
      chk("nom_len_err", len_err, 0);
    end
    drain();
    exp_pkts++;
    chk_counts("nom");

    // table of packet lengths, random consumer
    foreach (vecs[v]) begin
      rd_mode = 2;
      for (int i = 0; i < vecs[v].len; i++)
        send(8'($urandom_range(0, 255)), i == vecs[v].len - 1);
      drain();
      exp_pkts++;
      exp_errs += vecs[v].errs;
      chk_counts($sformatf("vec%0d", v));
    end

    // backpressure: fill 16, hold beat 16, single pop
    rd_mode = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 16; i++) send(8'(i), i == 7 || i == 15);
    @(negedge clk);
    chk("full_tready", s_tready, 0);
    chk("full_rd_valid", rd_valid, 1);
    s_tdata  = 8'd16;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    exp_q.push_back({1'b0, 8'd16});
    repeat (3) begin
      @(negedge clk);
      chk("hold_tready", s_tready, 0);
    end
    rd_mode = 3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("tready_after_pop", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("refull_tready", s_tready, 0);
    rd_mode = 1;
    for (int i = 17; i < 24; i++) send(8'(i), i == 23);
    drain();
    exp_pkts += 3;
    chk_counts("bp");

    // early tlast on beat 5
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), i == 4);
    chk("early_len_err", len_err, 1);
    @(posedge clk);
    #1;
    chk("early_len_err_drop", len_err, 0);
    drain();
    exp_pkts++;
    exp_errs++;
    chk_counts("early");

    // missing tlast: 10 beats, errors after beat 8 and 10
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h80 + i), i == 9);
      chk($sformatf("miss_len_err_b%0d", i + 1), len_err,
          (i == 7 || i == 9) ? 1 : 0);
    end
    drain();
    exp_pkts++;
    exp_errs += 2;
    chk_counts("miss");

    // reset in the middle of a packet
    rd_mode = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_pkt_count", pkt_count, 0);
    chk("midrst_err_count", err_count, 0);
    exp_q.delete();
    exp_pkts = 0;
    exp_errs = 0;
    pulses   = 0;
    #20;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd_mode = 1;
    for (int i = 0; i < 8; i++) send(8'(8'hE0 + i), i == 7);
    drain();
    exp_pkts++;
    chk_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
